// File: rtl/reset_seq.sv
// Reset sequencer beside the PLL: qualifies pll_lock through a synchroniser and
// a stability filter, then releases NUM_OUT reset domains one at a time.
module reset_seq #(
    parameter int NUM_OUT     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 64,
    parameter int STAGE_GAP   = 8,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               NRST,
    input  logic               pll_lock,
    input  logic               sw_reset,
    output logic [NUM_OUT-1:0] reset,
    output logic               ready,
    output logic [1:0]         state,
    output logic [7:0]         lock_loss_cnt
);

    localparam int STG_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic [NUM_OUT-1:0]     reset_q, reset_d;
    logic                   ready_q, ready_d;
    logic [7:0]             loss_q, loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes the chain a
    // real shift register instead of collapsing into one stage.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal driven here gets its hold value first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        reset_d = reset_q;
        ready_d = ready_q;
        loss_d  = loss_q;

        // Aborts outrank the normal sequence; lock loss outranks sw_reset.
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            stg_d   = '0;
            reset_d = '1;
            ready_d = 1'b0;
            if (loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else if (state_q != WAIT_LOCK && sw_reset) begin
            state_d = HOLD;
            cnt_d   = '0;
            stg_d   = '0;
            reset_d = '1;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                        stg_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        cnt_d = '0;
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (stg_q == STG_W'(i)) begin
                                reset_d[i] = 1'b0;
                            end
                        end
                        // Last domain released: ready rises on the same edge.
                        if (stg_q == STG_W'(NUM_OUT - 1)) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            stg_d = stg_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    // RUN holds everything until an abort.
                end
            endcase
        end
    end

    // NOTE: every flop, including the reset vector, is cleared by NRST so the
    // domains come up asserted the instant NRST falls, without a clock.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            stg_q   <= '0;
            reset_q <= '1;
            ready_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            reset_q <= reset_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    assign reset         = reset_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: directed timing scenarios plus randomized lock/sw_reset
// traffic, checked every cycle against a timeline model of the sequence.
module tb_reset_seq;

    localparam int NUM_OUT     = 3;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_FILTER = 16;
    localparam int HOLD_CYCLES = 64;
    localparam int STAGE_GAP   = 8;
    localparam int CNT_W       = 16;
    localparam int SEQ_LEN     = HOLD_CYCLES + NUM_OUT * STAGE_GAP;

    logic               clk = 1'b0;
    logic               NRST = 1'b0;
    logic               pll_lock = 1'b0;
    logic               sw_reset = 1'b0;
    logic [NUM_OUT-1:0] reset;
    logic               ready;
    logic [1:0]         state;
    logic [7:0]         lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    // Model: either filtering lock, or sequencing with m_t = edges since HOLD entry.
    bit m_seq;
    int m_filt;
    int m_t;
    int m_loss;
    bit lock_q[$];

    reset_seq #(
        .NUM_OUT(NUM_OUT), .SYNC_STAGES(SYNC_STAGES), .LOCK_FILTER(LOCK_FILTER),
        .HOLD_CYCLES(HOLD_CYCLES), .STAGE_GAP(STAGE_GAP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .NRST(NRST), .pll_lock(pll_lock), .sw_reset(sw_reset),
        .reset(reset), .ready(ready), .state(state), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        m_seq  = 1'b0;
        m_filt = 0;
        m_t    = 0;
        m_loss = 0;
        lock_q.delete();
        for (int i = 0; i < SYNC_STAGES; i++) lock_q.push_back(1'b0);
    endtask

    task automatic model_step(bit raw, bit sw);
        bit l;
        l = lock_q.pop_front();
        lock_q.push_back(raw);
        if (!m_seq) begin
            m_filt = l ? m_filt + 1 : 0;
            if (m_filt == LOCK_FILTER) begin
                m_seq = 1'b1;
                m_t   = 0;
            end
        end else if (!l) begin
            m_seq  = 1'b0;
            m_filt = 0;
            if (m_loss < 255) m_loss++;
        end else if (sw) begin
            m_t = 0;
        end else if (m_t < SEQ_LEN) begin
            m_t++;
        end
    endtask

    function automatic int released();
        int r;
        if (!m_seq || m_t < HOLD_CYCLES) return 0;
        r = (m_t - HOLD_CYCLES) / STAGE_GAP;
        return (r > NUM_OUT) ? NUM_OUT : r;
    endfunction

    function automatic logic [NUM_OUT-1:0] exp_reset();
        logic [NUM_OUT-1:0] v;
        v = '1;
        for (int i = 0; i < released(); i++) v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic [1:0] exp_state();
        if (!m_seq) return 2'd0;
        if (m_t < HOLD_CYCLES) return 2'd1;
        if (released() < NUM_OUT) return 2'd2;
        return 2'd3;
    endfunction

    task automatic compare_all();
        check("reset", reset, exp_reset());
        check("ready", ready, (released() == NUM_OUT && m_seq) ? 1 : 0);
        check("state", state, exp_state());
        check("lock_loss_cnt", lock_loss_cnt, m_loss);
    endtask

    // Inputs change just after the falling edge; outputs are checked on the next one.
    task automatic cycle(bit raw, bit sw);
        pll_lock = raw;
        sw_reset = sw;
        @(posedge clk);
        edge_n++;
        model_step(raw, sw);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_nrst(bit check_async);
        NRST = 1'b0;
        #1;
        if (check_async) begin
            check("nrst_reset", reset, {NUM_OUT{1'b1}});
            check("nrst_ready", ready, 0);
            check("nrst_state", state, 0);
        end
        model_reset();
        @(negedge clk);
        NRST   = 1'b1;
        edge_n = 0;
    endtask

    // Clean lock from edge base+1: exact release timeline relative to base.
    task automatic run_timed(int n, int base);
        int rel;
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 1'b0);
            rel = edge_n - base;
            if (rel == 17)  check("t_pre_hold", state, 0);
            if (rel == 18)  check("t_hold", state, 1);
            if (rel == 81)  check("t_pre_release", state, 1);
            if (rel == 82)  check("t_release", state, 2);
            if (rel == 89)  check("t_r0_before", reset, 3'b111);
            if (rel == 90)  check("t_r0", reset, 3'b110);
            if (rel == 98)  check("t_r1", reset, 3'b100);
            if (rel == 105) check("t_ready_before", ready, 0);
            if (rel == 106) begin
                check("t_r2", reset, 3'b000);
                check("t_ready", ready, 1);
                check("t_run", state, 3);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int p;
        int low_len;
        int sw_len;
        bit raw;
        bit sw;

        model_reset();
        repeat (2) @(negedge clk);
        check("por_reset", reset, {NUM_OUT{1'b1}});
        check("por_ready", ready, 0);
        check("por_state", state, 0);
        check("por_loss", lock_loss_cnt, 0);
        NRST = 1'b1;

        run_timed(110, 0);

        // NRST mid-RELEASE clears outputs without an edge, then timing repeats.
        do_nrst(1'b0);
        repeat (95) cycle(1'b1, 1'b0);
        check("mid_release", state, 2);
        do_nrst(1'b1);
        run_timed(110, 0);

        // One-cycle lock glitch restarts the filter; not a lock-loss event.
        do_nrst(1'b0);
        for (int k = 1; k <= 40; k++) begin
            cycle((k == 13) ? 1'b0 : 1'b1, 1'b0);
            if (edge_n == 18) check("glitch_no_hold", state, 0);
            if (edge_n == 30) check("glitch_pre_hold", state, 0);
            if (edge_n == 31) check("glitch_hold", state, 1);
        end
        check("glitch_loss", lock_loss_cnt, 0);

        // Lock loss in RUN: abort on the 3rd edge after pll_lock falls.
        repeat (80) cycle(1'b1, 1'b0);
        check("run_before_loss", ready, 1);
        cycle(1'b0, 1'b0);
        check("loss_edge1", ready, 1);
        cycle(1'b0, 1'b0);
        check("loss_edge2", ready, 1);
        cycle(1'b0, 1'b0);
        check("loss_edge3_ready", ready, 0);
        check("loss_edge3_reset", reset, 3'b111);
        check("loss_edge3_cnt", lock_loss_cnt, 1);
        repeat (5) cycle(1'b0, 1'b0);
        run_timed(110, edge_n);

        // sw_reset pulse in RUN: straight to HOLD, reset[0] falls 72 edges later.
        cycle(1'b1, 1'b1);
        check("sw_state", state, 1);
        check("sw_reset_vec", reset, 3'b111);
        p = edge_n;
        for (int k = 0; k < 80; k++) begin
            cycle(1'b1, 1'b0);
            if (edge_n - p == 71) check("sw_r0_before", reset, 3'b111);
            if (edge_n - p == 72) check("sw_r0", reset, 3'b110);
        end
        check("sw_loss_same", lock_loss_cnt, 1);

        // Lock loss and sw_reset together in RELEASE: lock loss wins.
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("both_pre", state, 2);
        cycle(1'b0, 1'b1);
        check("both_state", state, 0);
        check("both_cnt", lock_loss_cnt, 2);

        // Saturation of the lock-loss counter.
        repeat (300) begin
            repeat (20) cycle(1'b1, 1'b0);
            repeat (4) cycle(1'b0, 1'b0);
        end
        check("sat_255", lock_loss_cnt, 255);

        // Randomized traffic: short lock drops and sw_reset bursts.
        do_nrst(1'b0);
        low_len = 0;
        sw_len  = 0;
        repeat (4000) begin
            if (low_len == 0 && $urandom_range(0, 249) == 0) low_len = $urandom_range(1, 6);
            if (sw_len == 0 && $urandom_range(0, 149) == 0) sw_len = $urandom_range(1, 4);
            raw = (low_len == 0);
            sw  = (sw_len != 0);
            if (low_len != 0) low_len--;
            if (sw_len != 0) sw_len--;
            cycle(raw, sw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
Parametrised reset sequencer that replaces the single-output reset block beside the PLL. It qualifies pll_lock with a synchroniser and a stability filter. It then releases NUM_OUT active-high reset domains one at a time, STAGE_GAP cycles apart, and re-sequences on lock loss or on a software reset request. It runs on the PLL output clock and feeds every downstream video/system domain.

Parameters:
NUM_OUT, 3, number of reset outputs, released in index order 0..NUM_OUT-1 (>=1)
SYNC_STAGES, 2, flops in the pll_lock synchroniser (>=2)
LOCK_FILTER, 16, consecutive cycles synchronised lock must be high before sequencing starts (>=1)
HOLD_CYCLES, 64, cycles all resets stay asserted after lock qualifies (>=1)
STAGE_GAP, 8, cycles between successive reset releases (>=1)
CNT_W, 16, internal cycle-counter width; must hold max(LOCK_FILTER, HOLD_CYCLES, STAGE_GAP)-1

Ports:
clk  input  1  system clock (PLL output)
NRST  input  1  asynchronous active-low reset
pll_lock  input  1  raw PLL lock, asynchronous to clk
sw_reset  input  1  synchronous request to re-run the sequence; level, sampled each cycle
reset  output  NUM_OUT  active-high domain resets; bit i released i-th
ready  output  1  high when all resets are released (state RUN)
state  output  2  0=WAIT_LOCK, 1=HOLD, 2=RELEASE, 3=RUN
lock_loss_cnt  output  8  saturating count of lock-loss events since NRST

Behaviour:
- Clock is clk. Reset is NRST, asynchronous and active-low. While NRST=0, all flops clear immediately: reset=all ones, ready=0, state=WAIT_LOCK, lock_loss_cnt=0, synchroniser=0, counters=0.
- lock_s = pll_lock after SYNC_STAGES flops. All decisions below use lock_s only.
- Single counter cnt (CNT_W bits) and stage index stg (clog2(NUM_OUT) bits, min 1).
- WAIT_LOCK:
  - lock_s=0: cnt<=0.
  - lock_s=1 and cnt==LOCK_FILTER-1: go to HOLD, cnt<=0.
  - Otherwise cnt++.
- HOLD: cnt++. When cnt==HOLD_CYCLES-1: go to RELEASE, cnt<=0, stg<=0.
- RELEASE: cnt++. When cnt==STAGE_GAP-1: reset[stg]<=0, cnt<=0, stg++. If stg==NUM_OUT-1, go to RUN and ready<=1 on that same edge.
- RUN: hold outputs, no counting.
- Once released, a reset bit stays 0 until a re-sequence. Bits never release out of order.
- Abort, checked in HOLD, RELEASE and RUN, with priority over normal transitions:
  - lock_s=0: next edge sets reset=all ones, ready=0, state=WAIT_LOCK, cnt=0. lock_loss_cnt increments, saturating at 255.
  - else sw_reset=1: same outputs, but state=HOLD, cnt=0 (no filter re-run), no counter increment.
- sw_reset in WAIT_LOCK is ignored.
- sw_reset held high keeps the block in HOLD with cnt=0. The sequence resumes on the first cycle it is low.
- NUM_OUT=1: reset[0] and ready change on the same edge.
- Abort latency: one clk edge after lock_s falls, so SYNC_STAGES+1 edges from raw pll_lock falling.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Defaults, pll_lock=1 held, NRST released before edge 1 → reset[0] falls at edge 90, reset[1] at 98, reset[2] at 106 together with ready=1. state reads 1 at edge 18 and 2 at edge 82.
- NRST pulsed low mid-RELEASE (after edge 95) → reset=3'b111, ready=0, state=0 immediately, without a clock edge. The sequence then repeats the 106-edge timing after release.
- Lock glitch: pll_lock low for 1 cycle at WAIT_LOCK cnt=10 → filter restarts; HOLD entry delayed by 11+ cycles relative to the clean case; lock_loss_cnt stays 0.
- Lock loss in RUN: pll_lock falls → reset=all ones, ready=0 at the 3rd edge after the fall. lock_loss_cnt=1. Relock repeats the full 106-edge sequence measured from relock.
- sw_reset pulsed 1 cycle in RUN → all resets reassert next edge, state=1. reset[0] falls 72 edges after the HOLD entry; lock_loss_cnt unchanged.
- 300 lock-loss/relock cycles → lock_loss_cnt saturates at 255, no wrap. Simultaneous lock_s=0 and sw_reset=1 in RELEASE → state=WAIT_LOCK and the count increments.
